// File: rtl/mem_access_master_pkg.sv
// Shared definitions for the pipeline-to-byte-memory access master: default
// address map parameters and the access FSM state encoding.
package mem_access_master_pkg;

  localparam int unsigned BASE_ADDR_DFLT = 1024;
  localparam int unsigned DEPTH_DFLT     = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_master.sv
// Pipeline MEM-stage access master. Converts one 32-bit load/store request
// into four big-endian byte beats on a simple req/ack byte memory port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_r, req_w        pipeline load / store request (sampled in IDLE only)
//   adr, wdata          pipeline byte address and store data
//   rdata               load result, held until the next accepted load
//   freeze              stall to pipeline while an access is in progress
//   done                one-cycle pulse when an access completes
//   err                 one-cycle pulse on a rejected request
//   m_req, m_we         byte-beat request / write strobe to memory
//   m_adr, m_wdata      byte address and write byte of the current beat
//   m_rdata, m_ack      read byte and beat acknowledge from memory
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int unsigned BASE_ADDR = BASE_ADDR_DFLT,
  parameter int unsigned DEPTH     = DEPTH_DFLT,
  localparam int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_r,
  input  logic              req_w,
  input  logic [31:0]       adr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              freeze,
  output logic              done,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [7:0]        m_wdata,
  input  logic [7:0]        m_rdata,
  input  logic              m_ack
);

  localparam int unsigned BEAT_W    = 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_adr;
  logic [31:0]         r_wdata;
  logic                r_we;
  logic [BEAT_W-1:0]   r_beat;
  logic [31:0]         r_rdata;

  logic [31:0]         w_aligned;
  logic                w_in_range;
  logic                w_one_req;
  logic                w_accept;
  logic                w_beat_done;
  logic [4:0]          w_lsb;

  // Strip the pipeline offset (only from addresses at or above it) and word-align.
  function automatic logic [31:0] f_align(input logic [31:0] a);
    logic [31:0] ea;
    ea = (a >= 32'(BASE_ADDR)) ? (a - 32'(BASE_ADDR)) : a;
    return {ea[31:2], 2'b00};
  endfunction

  assign w_aligned  = f_align(adr);
  // 33-bit compare so the +3 can never wrap
  assign w_in_range = ({1'b0, w_aligned} + 33'd3) < 33'(DEPTH);
  assign w_one_req  = req_r ^ req_w;
  // Big-endian byte lane: beat 0 -> bits [31:24], beat 3 -> bits [7:0]
  assign w_lsb      = {~r_beat, 3'b000};
  assign rdata      = r_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_beat_done = 1'b0;
    freeze      = 1'b0;
    err         = 1'b0;
    done        = 1'b0;
    m_req       = 1'b0;
    m_we        = 1'b0;
    m_adr       = '0;
    m_wdata     = '0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          if (w_one_req && w_in_range) begin
            w_accept    = 1'b1;
            freeze      = 1'b1;
            w_state_nxt = BEAT;
          end else if (req_r || req_w) begin
            err = 1'b1;
          end
        end
      end
      BEAT: begin
        freeze  = 1'b1;
        m_req   = 1'b1;
        m_we    = r_we;
        m_adr   = r_adr + ADDR_W'(r_beat);
        m_wdata = r_wdata[w_lsb +: 8];
        if (m_ack) begin
          w_beat_done = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // Pipeline advances this cycle, so no request is looked at here
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Access context latch, beat counter and load assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adr   <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_beat  <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_adr   <= w_aligned[ADDR_W-1:0];
      r_wdata <= wdata;
      r_we    <= req_w;
      r_beat  <= '0;
    end else if (w_beat_done) begin
      if (!r_we) begin
        r_rdata[w_lsb +: 8] <= m_rdata;
      end
      r_beat <= r_beat + 2'd1;
    end
  end

endmodule

// File: doc/mem_access_master.md
MEM_ACCESS_MASTER -- requirements
Module: mem_access_master

Interface
REQ-001 Parameter BASE_ADDR, default 1024: pipeline address offset subtracted from addresses >= BASE_ADDR.
REQ-002 Parameter DEPTH, default 256: memory size in bytes; ADDR_W = log2(DEPTH) = 8.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_r  input  1  pipeline load request (MEM stage).
REQ-006 req_w  input  1  pipeline store request (MEM stage).
REQ-007 adr  input  32  pipeline byte address.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load result, held until next accepted load.
REQ-010 freeze  output  1  stall to pipeline while an access is in progress.
REQ-011 done  output  1  one-cycle pulse when an access completes.
REQ-012 err  output  1  one-cycle pulse on rejected request.
REQ-013 m_req  output  1  byte-beat request to memory.
REQ-014 m_we  output  1  beat is a write.
REQ-015 m_adr  output  ADDR_W  byte address of current beat.
REQ-016 m_wdata  output  8  write byte.
REQ-017 m_rdata  input  8  read byte, valid in the cycle m_ack=1.
REQ-018 m_ack  input  1  memory accepts/completes current beat.

Function
REQ-019 FSM states IDLE, BEAT, DONE; reset state IDLE.
REQ-020 Effective address: ea = adr - BASE_ADDR if adr >= BASE_ADDR, else adr; aligned = {ea[31:2], 2'b00}.
REQ-021 IDLE, exactly one of req_r/req_w high, aligned+3 < DEPTH: latch aligned, wdata, direction; beat counter := 0; go BEAT; freeze=1 combinationally that cycle.
REQ-022 IDLE, req_r and req_w both high, or aligned+3 >= DEPTH: err=1 for that cycle, no memory access, freeze=0, stay IDLE.
REQ-023 BEAT: m_req=1, m_we=latched direction, m_adr = aligned[ADDR_W-1:0] + beat, m_wdata = wdata byte [31-8*beat -: 8] (big-endian, beat 0 = MSB).
REQ-024 BEAT: m_req held with stable m_adr/m_we/m_wdata until m_ack=1; m_ack while m_req=0 ignored.
REQ-025 BEAT, m_ack=1, read: rdata[31-8*beat -: 8] := m_rdata; beat increments; after beat 3 ack go DONE.
REQ-026 DONE: freeze=0, done=1, m_req=0; next cycle IDLE; pipeline advances during DONE, so a held request is not re-issued.
REQ-027 freeze=1 in BEAT; freeze=0 in DONE and in IDLE unless REQ-021 applies.
REQ-028 Minimum latency with m_ack tied high: freeze high 5 cycles (accept + 4 beats), done in cycle 6.
REQ-029 Stores leave rdata unchanged; rdata updates byte-wise during a load, and the full word is valid from the cycle done=1.
REQ-030 Inputs other than m_ack/m_rdata ignored outside IDLE.

Reset
REQ-031 rst=1 at any state, including mid-BEAT: next state IDLE, beat=0, rdata=0, m_req=0, m_we=0, m_adr=0, m_wdata=0, done=0, err=0, freeze=0.
REQ-032 Partially written word after mid-access reset is not retried or repaired.

Structure
REQ-033 Shared package holds BASE_ADDR/DEPTH defaults and the state enumeration.
REQ-034 Single module, no sub-modules; address translation is a local combinational function.

Verification
REQ-035 Store adr=1028, wdata=0xDEADBEEF, m_ack=1 -> beats m_adr 4,5,6,7 bytes DE,AD,BE,EF, m_we=1; freeze 5 cycles; done pulse.
REQ-036 Load adr=1028 against model holding the above -> rdata=0xDEADBEEF at done; m_we=0 all beats.
REQ-037 Load adr=1030 (unaligned) -> same beats m_adr 4..7 as aligned 1028.
REQ-038 m_ack delayed 3 cycles per beat -> m_adr/m_wdata stable while waiting; freeze 1+4*4=17 cycles.
REQ-039 Load adr=1276 (aligned 252 ok) vs adr=1280 (256) -> first accepted; second err=1 one cycle, no m_req, freeze 0.
REQ-040 rst during beat 2 of a store -> next cycle IDLE, m_req=0, rdata=0; following load completes normally.
